// File: rtl/chain_master.sv
// rtl/chain_master.sv - serial shift-chain master with readback, cookie and echo checks
module chain_master #(
   parameter int               WIDTH  = 16,
   parameter int               DIV    = 4,
   parameter logic [WIDTH-1:0] COOKIE = WIDTH'(16'hCAFE)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_miso,
   output logic             o_sclk,
   output logic             o_mosi,
   output logic             o_load,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_cookie,
   output logic             o_echo_ok
);

   localparam int PW = $clog2(DIV);
   localparam int BW = $clog2(WIDTH);

   typedef enum logic [2:0] {IDLE, LOW, HIGH, LATCH, DONE} state_t;

   state_t           state_q;
   logic [PW-1:0]    phase_q;
   logic [BW-1:0]    bit_q;
   logic [WIDTH-1:0] shift_q, cap_q, rx_q, last_q, rdata_q;
   logic             cookie_q, echo_q, sclk_q, mosi_q, load_q, busy_q, done_q;
   logic             rst_sync_q;
   logic             phase_last;

   assign phase_last = (phase_q == PW'(DIV - 1));

   // Reset release is retimed by one flop; starts are refused until it has propagated.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) rst_sync_q <= 1'b0;
      else          rst_sync_q <= 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         phase_q  <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         cap_q    <= '0;
         rx_q     <= '0;
         last_q   <= '0;
         rdata_q  <= '0;
         cookie_q <= (COOKIE == '0);
         echo_q   <= 1'b1;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         load_q   <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_start && rst_sync_q) begin
                  shift_q <= i_wdata;
                  cap_q   <= i_wdata;
                  bit_q   <= BW'(WIDTH - 1);
                  phase_q <= '0;
                  load_q  <= 1'b0;
                  mosi_q  <= i_wdata[WIDTH-1];
                  busy_q  <= 1'b1;
                  state_q <= LOW;
               end
            end
            LOW: begin
               if (phase_last) begin
                  rx_q    <= {rx_q[WIDTH-2:0], i_miso};
                  phase_q <= '0;
                  sclk_q  <= 1'b1;
                  state_q <= HIGH;
               end else begin
                  phase_q <= phase_q + 1'b1;
               end
            end
            HIGH: begin
               if (phase_last) begin
                  shift_q <= {shift_q[WIDTH-2:0], 1'b0};
                  phase_q <= '0;
                  sclk_q  <= 1'b0;
                  if (bit_q == '0) begin
                     load_q  <= 1'b1;
                     mosi_q  <= 1'b0;
                     state_q <= LATCH;
                  end else begin
                     bit_q   <= bit_q - 1'b1;
                     mosi_q  <= shift_q[WIDTH-2];
                     state_q <= LOW;
                  end
               end else begin
                  phase_q <= phase_q + 1'b1;
               end
            end
            LATCH: begin
               if (phase_last) begin
                  phase_q <= '0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  phase_q <= phase_q + 1'b1;
               end
            end
            DONE: begin
               // Echo compares against the word written by the transaction before this one.
               rdata_q  <= rx_q;
               last_q   <= cap_q;
               cookie_q <= (rx_q == COOKIE);
               echo_q   <= (rx_q == last_q);
               done_q   <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_sclk    = sclk_q;
   assign o_mosi    = mosi_q;
   assign o_load    = load_q;
   assign o_busy    = busy_q;
   assign o_done    = done_q;
   assign o_rdata   = rdata_q;
   assign o_cookie  = cookie_q;
   assign o_echo_ok = echo_q;

endmodule

// File: doc/chain_master.md
CHAIN_MASTER -- requirements
Module: chain_master

Interface
REQ-001 Parameter WIDTH, default 16, chain length in bits (>=2).
REQ-002 Parameter DIV, default 4, half-period of o_sclk in i_clk cycles (>=2).
REQ-003 Parameter COOKIE, default 16'hCAFE (WIDTH bits), magic word compared against readback.
REQ-004 i_clk  input  1  single clock; all state on rising edge.
REQ-005 i_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 i_start  input  1  transaction request, sampled only in IDLE.
REQ-007 i_wdata  input  WIDTH  word to shift out, captured on accepted start.
REQ-008 i_miso  input  1  serial data from chain MSB.
REQ-009 o_sclk  output  1  chain shift clock.
REQ-010 o_mosi  output  1  serial data to chain, MSB first.
REQ-011 o_load  output  1  chain load/nCS; low while shifting, rising edge latches chain.
REQ-012 o_busy  output  1  high from cycle after accepted start through DONE cycle.
REQ-013 o_done  output  1  one-cycle pulse at end of transaction.
REQ-014 o_rdata  output  WIDTH  word shifted out of chain during last transaction.
REQ-015 o_cookie  output  1  o_rdata == COOKIE.
REQ-016 o_echo_ok  output  1  o_rdata == word written by the previous completed transaction.

Function
REQ-017 States SHALL be IDLE, LOW, HIGH, LATCH, DONE; phase counter counts DIV cycles per LOW/HIGH/LATCH.
REQ-018 IDLE: o_sclk=0, o_load=1, o_mosi=0, o_busy=0; i_start=1 captures i_wdata into shift register, loads bit counter WIDTH-1, next state LOW.
REQ-019 LOW (DIV cycles): o_load=0, o_sclk=0, o_mosi=shift[WIDTH-1]; in last LOW cycle i_miso sampled into receive register LSB (receive shifts left).
REQ-020 HIGH (DIV cycles): o_sclk=1, o_load=0, o_mosi held; at end shift register shifts left; counter 0 -> LATCH, else decrement -> LOW.
REQ-021 LATCH (DIV cycles): o_sclk=0, o_load=1, o_mosi=0; then DONE.
REQ-022 DONE (1 cycle): o_done=1, o_busy=1; o_rdata <= receive register, last-written register <= captured word, old last-written retained for o_echo_ok compare; next IDLE.
REQ-023 o_echo_ok SHALL compare new o_rdata with last-written value held before this DONE; both update together so compare is registered and valid from cycle after DONE.
REQ-024 o_cookie, o_echo_ok registered, updated only in DONE.
REQ-025 Latency: o_busy high exactly 2*WIDTH*DIV + DIV + 1 cycles; o_done in last of them.
REQ-026 i_start while busy SHALL be ignored (not queued); i_start in DONE cycle ignored; i_start held high restarts from IDLE next cycle (back-to-back, one IDLE cycle between).
REQ-027 i_wdata changes after capture SHALL not affect transaction.
REQ-028 o_sclk, o_mosi, o_load SHALL be driven from flops (glitch-free); o_load never low while o_sclk transitions outside LOW/HIGH.
REQ-029 Exactly WIDTH rising o_sclk edges per transaction, all while o_load=0.

Reset
REQ-030 i_rst_n low SHALL asynchronously force IDLE: o_sclk=0, o_load=1, o_mosi=0, o_busy=0, o_done=0, o_rdata=0, last-written=0, o_cookie=(COOKIE==0), o_echo_ok=1.
REQ-031 Reset mid-transaction SHALL abort without DONE; resulting o_load rise is permitted (chain latches partial data); o_rdata unchanged from reset value.
REQ-032 Deassertion SHALL be synchronized internally; first start accepted on second rising i_clk after release.

Verification
REQ-033 DIV=2, WIDTH=16, model chain attached: start with 16'hCAFE from reset -> o_busy 67 cycles, 16 sclk edges, o_done once, o_rdata=0, o_echo_ok=1, o_cookie=0.
REQ-034 Second start with 16'h1234 -> o_rdata=16'hCAFE, o_cookie=1, o_echo_ok=1, chain latched 16'h1234.
REQ-035 Chain model replaced by stuck-0 i_miso, write 16'hFFFF twice -> o_rdata=0, o_echo_ok=0.
REQ-036 i_start pulsed every cycle during transaction and in DONE -> exactly one transaction, next begins only after IDLE cycle.
REQ-037 i_rst_n low during 5th HIGH phase -> immediate o_load=1, o_sclk=0, o_busy=0, no o_done, o_rdata=0.
REQ-038 DIV=3 run -> each sclk high/low exactly 3 cycles, o_busy 100 cycles.
